// File: rtl/core_pkg.sv
// Shared encodings and types for the ID/EX boundary of the 5-stage core.
package core_pkg;

    // ALU operation classes
    localparam logic [3:0] ALUOP_ADD  = 4'b0000;
    localparam logic [3:0] ALUOP_SUB  = 4'b0001;
    localparam logic [3:0] ALUOP_LOGIC = 4'b0010;
    localparam logic [3:0] ALUOP_SHIFT = 4'b0011;
    localparam logic [3:0] ALUOP_SLT  = 4'b0100;
    localparam logic [3:0] ALUOP_BR   = 4'b0101;
    localparam logic [3:0] ALUOP_LUI  = 4'b0110;

    // Writeback source select
    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_MEM = 2'b01;
    localparam logic [1:0] WB_PC4 = 2'b10;
    localparam logic [1:0] WB_IMM = 2'b11;

    // Next-PC select
    localparam logic [1:0] PCSIG_SEQ  = 2'b00;
    localparam logic [1:0] PCSIG_BR   = 2'b01;
    localparam logic [1:0] PCSIG_JAL  = 2'b10;
    localparam logic [1:0] PCSIG_JALR = 2'b11;

    // Decode control bundle carried from ID into EX
    typedef struct packed {
        logic       jal;
        logic       MemRead;
        logic       MemWrite;
        logic       ALUSrc1;
        logic       ALUSrc2;
        logic       RegWrite;
        logic [1:0] WhatToReg;
        logic [1:0] pcSig;
        logic       PC_enable;
        logic       PC_rst;
        logic [3:0] ALUOP;
    } ctrl_t;

    localparam int unsigned CTRL_W = $bits(ctrl_t);

    // Control bundle of a pipeline bubble (also the reset value)
    localparam ctrl_t BUBBLE_CTRL = '{
        jal:       1'b0,
        MemRead:   1'b0,
        MemWrite:  1'b0,
        ALUSrc1:   1'b0,
        ALUSrc2:   1'b0,
        RegWrite:  1'b0,
        WhatToReg: WB_ALU,
        pcSig:     PCSIG_SEQ,
        PC_enable: 1'b1,
        PC_rst:    1'b0,
        ALUOP:     ALUOP_ADD
    };

    // Halt sequencer states
    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } ex_state_t;

endpackage

// File: rtl/id_ex_stage_hazard_detect.sv
// Load-use hazard detection: a load in EX whose destination feeds the
// instruction currently in ID forces a one-cycle stall.
module hazard_detect (
    input  logic       ex_valid,
    input  logic       ex_mem_read,
    input  logic [4:0] ex_rd,
    input  logic       id_valid,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    output logic       stall
);

    assign stall = ex_valid & ex_mem_read & (ex_rd != 5'd0) &
                   ((ex_rd == id_rs1) | (ex_rd == id_rs2)) & id_valid;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with bubble insertion for load-use stalls and
// branch flushes, plus the ECALL/FENCE restart and EBREAK drain/halt sequencer.
module id_ex_stage
    import core_pkg::*;
#(
    parameter int unsigned DW           = 32,
    parameter int unsigned DRAIN_CYCLES = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          id_valid,
    input  logic          id_jal,
    input  logic          id_MemRead,
    input  logic          id_MemWrite,
    input  logic          id_ALUSrc1,
    input  logic          id_ALUSrc2,
    input  logic          id_RegWrite,
    input  logic [1:0]    id_WhatToReg,
    input  logic [1:0]    id_pcSig,
    input  logic          id_PC_enable,
    input  logic          id_PC_rst,
    input  logic [3:0]    id_ALUOP,
    input  logic [DW-1:0] id_pc,
    input  logic [DW-1:0] id_rs1_data,
    input  logic [DW-1:0] id_rs2_data,
    input  logic [DW-1:0] id_imm,
    input  logic [4:0]    id_rs1,
    input  logic [4:0]    id_rs2,
    input  logic [4:0]    id_rd,
    input  logic [2:0]    id_funct3,
    input  logic          id_inst30,
    input  logic          ex_flush,
    output logic          ex_valid,
    output logic          ex_jal,
    output logic          ex_MemRead,
    output logic          ex_MemWrite,
    output logic          ex_ALUSrc1,
    output logic          ex_ALUSrc2,
    output logic          ex_RegWrite,
    output logic [1:0]    ex_WhatToReg,
    output logic [1:0]    ex_pcSig,
    output logic          ex_PC_enable,
    output logic          ex_PC_rst,
    output logic [3:0]    ex_ALUOP,
    output logic [DW-1:0] ex_pc,
    output logic [DW-1:0] ex_rs1_data,
    output logic [DW-1:0] ex_rs2_data,
    output logic [DW-1:0] ex_imm,
    output logic [4:0]    ex_rs1,
    output logic [4:0]    ex_rs2,
    output logic [4:0]    ex_rd,
    output logic [2:0]    ex_funct3,
    output logic          ex_inst30,
    output logic          ex_pc_rst,
    output logic          pc_write,
    output logic          ifid_write,
    output logic          halted
);

    localparam int unsigned CNT_W = $clog2(DRAIN_CYCLES + 1);
    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_CYCLES - 1);

    ex_state_t        state;
    logic [CNT_W-1:0] drain_cnt;
    logic             halted_q;

    ctrl_t            id_ctrl;
    ctrl_t            ex_ctrl;
    logic             ex_valid_q;

    logic             stall;
    logic             running;
    logic             restart;
    logic             ebreak;
    logic             insert_bubble;

    hazard_detect u_hazard (
        .ex_valid    (ex_valid_q),
        .ex_mem_read (ex_ctrl.MemRead),
        .ex_rd       (ex_rd),
        .id_valid    (id_valid),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .stall       (stall)
    );

    // Pack the decode controls into the shared bundle layout
    always_comb begin
        id_ctrl           = BUBBLE_CTRL;
        id_ctrl.jal       = id_jal;
        id_ctrl.MemRead   = id_MemRead;
        id_ctrl.MemWrite  = id_MemWrite;
        id_ctrl.ALUSrc1   = id_ALUSrc1;
        id_ctrl.ALUSrc2   = id_ALUSrc2;
        id_ctrl.RegWrite  = id_RegWrite;
        id_ctrl.WhatToReg = id_WhatToReg;
        id_ctrl.pcSig     = id_pcSig;
        id_ctrl.PC_enable = id_PC_enable;
        id_ctrl.PC_rst    = id_PC_rst;
        id_ctrl.ALUOP     = id_ALUOP;
    end

    assign running = (state == ST_RUN);
    assign restart = running & ex_valid_q & ex_ctrl.PC_rst;
    assign ebreak  = running & ex_valid_q & ~ex_ctrl.PC_enable & ~ex_ctrl.PC_rst;

    // Any non-RUN state, restart, EBREAK, flush or stall turns the next EX slot
    // into a bubble; an empty ID slot is loaded as a bubble too.
    assign insert_bubble = ~running | restart | ebreak | ex_flush | stall | ~id_valid;

    // Flush and restart redirect fetch, so they override the load-use freeze
    assign pc_write   = running & (~stall | ex_flush | restart);
    assign ifid_write = pc_write;
    assign ex_pc_rst  = restart;
    assign halted     = halted_q;

    // Pipeline register: reset and bubble share the same contents
    always_ff @(posedge clk) begin
        if (rst || insert_bubble) begin
            ex_valid_q  <= 1'b0;
            ex_ctrl     <= BUBBLE_CTRL;
            ex_pc       <= '0;
            ex_rs1_data <= '0;
            ex_rs2_data <= '0;
            ex_imm      <= '0;
            ex_rs1      <= '0;
            ex_rs2      <= '0;
            ex_rd       <= '0;
            ex_funct3   <= '0;
            ex_inst30   <= 1'b0;
        end else begin
            ex_valid_q  <= 1'b1;
            ex_ctrl     <= id_ctrl;
            ex_pc       <= id_pc;
            ex_rs1_data <= id_rs1_data;
            ex_rs2_data <= id_rs2_data;
            ex_imm      <= id_imm;
            ex_rs1      <= id_rs1;
            ex_rs2      <= id_rs2;
            ex_rd       <= id_rd;
            ex_funct3   <= id_funct3;
            ex_inst30   <= id_inst30;
        end
    end

    // Halt sequencer: EBREAK in EX drains the back end, then halts until reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_RUN;
            drain_cnt <= '0;
            halted_q  <= 1'b0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (ebreak) begin
                        state     <= ST_DRAIN;
                        drain_cnt <= '0;
                    end
                end
                ST_DRAIN: begin
                    drain_cnt <= drain_cnt + 1'b1;
                    if (drain_cnt == DRAIN_LAST) begin
                        state    <= ST_HALTED;
                        halted_q <= 1'b1;
                    end
                end
                ST_HALTED: begin
                    halted_q <= 1'b1;
                end
                default: begin
                    state     <= ST_RUN;
                    drain_cnt <= '0;
                    halted_q  <= 1'b0;
                end
            endcase
        end
    end

    assign ex_valid     = ex_valid_q;
    assign ex_jal       = ex_ctrl.jal;
    assign ex_MemRead   = ex_ctrl.MemRead;
    assign ex_MemWrite  = ex_ctrl.MemWrite;
    assign ex_ALUSrc1   = ex_ctrl.ALUSrc1;
    assign ex_ALUSrc2   = ex_ctrl.ALUSrc2;
    assign ex_RegWrite  = ex_ctrl.RegWrite;
    assign ex_WhatToReg = ex_ctrl.WhatToReg;
    assign ex_pcSig     = ex_ctrl.pcSig;
    assign ex_PC_enable = ex_ctrl.PC_enable;
    assign ex_PC_rst    = ex_ctrl.PC_rst;
    assign ex_ALUOP     = ex_ctrl.ALUOP;

endmodule
